// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the write-side control of the 10-bit FIFO.
// No logic; latency n/a.
// Backpressure n/a.
package fifo_ctrl_pkg;

    localparam int FIFO_DATA_W = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of a requester index; never zero, even for a single requester.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ID_W    = id_w(DEF_NUM_REQ);

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority select: first set request after last_grant, wrapping.
// Latency: purely combinational.
// Backpressure: none, the caller decides when the pick is taken.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    pick,
    output logic               any_req
);

    logic found;
    int   idx;

    always_comb begin
        pick    = '0;
        found   = 1'b0;
        idx     = 0;
        any_req = |req;
        for (int j = 1; j <= NUM_REQ; j++) begin
            idx = (int'(last_grant) + j) % NUM_REQ;
            if (!found && req[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter_10bit.sv
// Round-robin, burst-limited sharing of the FIFO write port among NUM_REQ sources.
// Latency: first word written 1 cycle after request seen in IDLE; 1 bubble per grant release.
// Backpressure: fifo_full holds the grant and drops req_ready without consuming burst credit.
module fifo_wr_arbiter_10bit
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int MAX_BURST = 4
)(
    input  logic                      write_clk,
    input  logic                      write_rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic                      fifo_write_enable,
    output logic                      grant_valid,
    output logic [id_w(NUM_REQ)-1:0]  grant_id,
    output logic [15:0]               word_count
);

    localparam int ID_W = id_w(NUM_REQ);

    arb_state_t        state, state_nxt;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   pick;
    logic              any_req;
    logic [3:0]        burst_cnt;
    logic [DATA_W-1:0] words [NUM_REQ];
    logic              in_grant;
    logic              cur_valid;
    logic              xfer;
    logic              burst_done;

    rr_pick #(
        .NUM_REQ    (NUM_REQ),
        .ID_W       (ID_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .pick       (pick),
        .any_req    (any_req)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign in_grant          = (state == GRANT);
    assign cur_valid         = req_valid[grant_id];
    assign xfer              = in_grant && cur_valid && !fifo_full;
    assign burst_done        = xfer && (burst_cnt == 4'(MAX_BURST - 1));
    assign fifo_write_enable = xfer;
    assign fifo_data_in      = in_grant ? words[grant_id] : '0;
    assign grant_valid       = in_grant;

    always_comb begin
        req_ready = '0;
        if (in_grant && !fifo_full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   if (!cur_valid || burst_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Last grant seeds the next search so requester 0 wins first out of reset.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            burst_cnt  <= '0;
            word_count <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_id   <= pick;
                last_grant <= pick;
                burst_cnt  <= '0;
            end else if (xfer) begin
                burst_cnt  <= burst_cnt + 4'd1;
            end
            if (xfer) begin
                word_count <= word_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter_10bit.sv
// Self-checking bench: directed scenarios plus random traffic against a grant-level model.
// A second small instance with long bursts streams words to exercise word_count wrap.
module tb_fifo_wr_arbiter_10bit;

    localparam int N  = 4;
    localparam int DW = 10;
    localparam int MB = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic [DW-1:0]   fifo_data_in;
    logic            fifo_write_enable;
    logic            grant_valid;
    logic [1:0]      grant_id;
    logic [15:0]     word_count;

    logic            w_rst_n;
    logic [1:0]      w_valid;
    logic [2*DW-1:0] w_data;
    logic [1:0]      w_ready;
    logic [DW-1:0]   w_fifo_data;
    logic            w_we;
    logic            w_gv;
    logic [0:0]      w_gid;
    logic [15:0]     w_count;
    logic            wrap_done;

    int n_checks = 0;
    int n_errors = 0;

    // Grant-level reference state
    int owner;
    int last_owner;
    int shown_id;
    int taken;
    int exp_count;
    int acc [N];

    fifo_wr_arbiter_10bit #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .write_clk         (clk),
        .write_rst_n       (rst_n),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .fifo_full         (fifo_full),
        .fifo_data_in      (fifo_data_in),
        .fifo_write_enable (fifo_write_enable),
        .grant_valid       (grant_valid),
        .grant_id          (grant_id),
        .word_count        (word_count)
    );

    fifo_wr_arbiter_10bit #(.NUM_REQ(2), .DATA_W(DW), .MAX_BURST(15)) u_wrap (
        .write_clk         (clk),
        .write_rst_n       (w_rst_n),
        .req_valid         (w_valid),
        .req_data          (w_data),
        .req_ready         (w_ready),
        .fifo_full         (1'b0),
        .fifo_data_in      (w_fifo_data),
        .fifo_write_enable (w_we),
        .grant_valid       (w_gv),
        .grant_id          (w_gid),
        .word_count        (w_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic refresh_data();
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = DW'((i << 8) | ((acc[i] + 1) & 255));
        end
    endtask

    // Compare on the falling edge, then advance the model by the coming rising edge.
    initial begin
        int      c;
        logic    we_e;
        logic [N-1:0] rdy_e;
        for (int i = 0; i < N; i++) acc[i] = 0;
        refresh_data();
        owner = -1; last_owner = N - 1; shown_id = 0; taken = 0; exp_count = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                owner = -1; last_owner = N - 1; shown_id = 0; taken = 0; exp_count = 0;
                chk("rst_gv", grant_valid, 0);
                chk("rst_we", fifo_write_enable, 0);
                chk("rst_ready", req_ready, 0);
                chk("rst_gid", grant_id, 0);
                chk("rst_count", word_count, 0);
            end else begin
                we_e  = (owner >= 0) && req_valid[owner] && !fifo_full;
                rdy_e = '0;
                if (owner >= 0 && !fifo_full) rdy_e[owner] = 1'b1;
                chk("gv", grant_valid, owner >= 0);
                chk("gid", grant_id, shown_id);
                chk("ready", req_ready, rdy_e);
                chk("we", fifo_write_enable, we_e);
                chk("data", fifo_data_in, (owner >= 0) ? req_data[owner*DW +: DW] : 0);
                chk("count", word_count, exp_count & 16'hFFFF);
                if (owner < 0) begin
                    for (int j = 1; j <= N; j++) begin
                        c = (last_owner + j) % N;
                        if (owner < 0 && req_valid[c]) owner = c;
                    end
                    if (owner >= 0) begin
                        last_owner = owner; shown_id = owner; taken = 0;
                    end
                end else begin
                    if (we_e) begin
                        exp_count++; taken++; acc[owner]++;
                    end
                    if (!req_valid[owner] || taken == MB) owner = -1;
                end
                refresh_data();
            end
        end
    end

    // Long-burst instance: count after edge n is n - n/16 (15 writes then one bubble).
    initial begin
        w_rst_n = 1'b0; w_valid = 2'b01; w_data = '0; wrap_done = 1'b0;
        @(posedge clk); #1;
        w_rst_n = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 69906; n++) begin
            @(posedge clk);
            if (n == 100 || n >= 69902) begin
                #1;
                chk("wrap_count", w_count, (n - n / 16) & 16'hFFFF);
            end
        end
        wrap_done = 1'b1;
    end

    initial begin
        int guard;
        rst_n = 1'b0; req_valid = '0; fifo_full = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);

        // Single requester, two bursts separated by a bubble
        req_valid = 4'b0001;
        step(10);
        chk("t1_count", word_count, 8);
        req_valid = '0;
        step(2);

        // All requesters from reset: order 0,1,2,3,0
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        step(25);
        chk("t2_count", word_count, 20);
        req_valid = '0;
        step(2);

        // Full stall during requester 1's grant
        req_valid = 4'b0010;
        step(2);
        fifo_full = 1'b1;
        #1;
        chk("t3_ready", req_ready, 0);
        chk("t3_we", fifo_write_enable, 0);
        chk("t3_gv", grant_valid, 1);
        step(4);
        fifo_full = 1'b0;
        step(3);
        chk("t3_count", word_count, 24);
        req_valid = '0;
        step(2);

        // Requester 2 withdraws after two words; requester 3 goes next
        req_valid = 4'b1100;
        step(3);
        req_valid = 4'b1000;
        step(1);
        req_valid = 4'b1100;
        step(1);
        chk("t4_gid", grant_id, 3);
        chk("t4_gv", grant_valid, 1);
        chk("t4_count", word_count, 26);
        req_valid = '0;
        step(4);

        // Asynchronous reset mid-burst
        req_valid = 4'b1111;
        step(3);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_gv", grant_valid, 0);
        chk("t5_we", fifo_write_enable, 0);
        chk("t5_ready", req_ready, 0);
        chk("t5_count", word_count, 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("t5_gid", grant_id, 0);
        chk("t5_gvq", grant_valid, 1);
        step(3);
        req_valid = '0;
        step(6);

        // Random traffic, stalls and occasional resets
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) req_valid[i] = ~req_valid[i];
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            step(1);
        end
        rst_n = 1'b1; req_valid = '0; fifo_full = 1'b0;

        guard = 0;
        while (!wrap_done && guard < 80000) begin
            @(posedge clk);
            guard++;
        end
        if (!wrap_done) chk("wrap_timeout", 0, 1);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter_10bit.md
Name: fifo_wr_arbiter_10bit

Overview:
- Write-side scheduler that shares the single write port of the 10-bit dual-clock FIFO between NUM_REQ symbol sources in the QAM modulator stack.
- Arbitrates round-robin and grants in bursts of up to MAX_BURST words.
- Gates writes on the FIFO's full flag and keeps a running count of words written.
- Lives entirely in the write clock domain; drives the FIFO's data_in/write_enable and consumes its full output.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 10, word width; must match FIFO data width
MAX_BURST, 4, max words per grant before forced re-arbitration (1..15)

Ports:
write_clk  in  1  write-domain clock
write_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester word-available flag
req_data  in  NUM_REQ*DATA_W  packed words; requester i at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  per-requester accept strobe, combinational
fifo_full  in  1  full flag from FIFO, write-domain registered
fifo_data_in  out  DATA_W  word to FIFO data_in, combinational mux
fifo_write_enable  out  1  FIFO write strobe, combinational
grant_valid  out  1  registered; high in GRANT state
grant_id  out  clog2(NUM_REQ)  registered; current/last granted requester
word_count  out  16  registered; total words written, wraps at 65535->0

Behaviour:
- Clock/reset: one clock, write_clk; reset is asynchronous and active-low, write_rst_n; all state is reset asynchronously.
- Reset values: state=IDLE, grant_valid=0, grant_id=0, last_grant=NUM_REQ-1 (so requester 0 has first priority), burst_cnt=0, word_count=0. Consequently req_ready=0 and fifo_write_enable=0.
- Reset mid-burst aborts the grant immediately; no write occurs in the reset cycle.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If any req_valid is high, pick the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Next cycle: state=GRANT, grant_id=pick, last_grant=pick, burst_cnt=0.
  - If no req_valid is high, stay in IDLE.
- Transfer condition: xfer = (state==GRANT) && req_valid[grant_id] && !fifo_full.
  - req_ready[grant_id] = (state==GRANT) && !fifo_full; all other ready bits are 0.
  - fifo_write_enable = xfer.
  - fifo_data_in = req_data word for grant_id whenever in GRANT, otherwise 0.
- A transfer increments word_count and burst_cnt on the same edge.
- GRANT exits to IDLE on the edge after either:
  - the transfer that makes burst_cnt reach MAX_BURST, or
  - any cycle in which req_valid[grant_id]=0 (requester withdraws).
  - Otherwise the FSM stays in GRANT.
- Full stall: while fifo_full=1 in GRANT, hold grant, no write, burst_cnt frozen; the stall does not count toward the burst.
- Full deasserting resumes writes the same cycle it is observed low.
- Latency:
  - First word of a grant is written 1 cycle after the request is seen in IDLE.
  - Each grant release costs one IDLE bubble cycle.
  - Sustained throughput is MAX_BURST words per MAX_BURST+1 cycles.
- Fairness: a requester that holds valid continuously is served within (NUM_REQ-1)*(MAX_BURST+1)+1 cycles of the previous grant ending, provided the FIFO is not full.
- Requesters may drop req_valid at any time. A word is consumed only on a cycle where req_valid and req_ready are both high.
- word_count wraps silently; no saturation.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - FIFO_DATA_W = 10
  - state encoding: IDLE = 1'b0, GRANT = 1'b1
  - helper constant for the grant_id width
- One sub-module, rr_pick: purely combinational round-robin priority select.
  - Inputs: request vector, last_grant.
  - Outputs: pick index, any_req.
  - Instantiated once; the FSM, counters and muxes stay in the top block.

Test Plan:
1. Reset, then req_valid=4'b0001 held, req_data[0] incrementing 0x001..0x008, fifo_full=0.
   - Expect grant_id=0 one cycle after valid.
   - Writes 0x001..0x004 on 4 consecutive cycles, 1 IDLE bubble, then 0x005..0x008.
   - word_count=8.
2. req_valid=4'b1111 all held.
   - Expect grant order 0,1,2,3,0, with 4 writes per grant and one bubble between grants.
   - word_count=20 after 25 active cycles.
3. Requester 1 granted; fifo_full=1 for cycles 2-5 of the grant.
   - Expect req_ready[1]=0 and fifo_write_enable=0 during the stall, grant_valid held.
   - Exactly 4 writes total once full clears.
4. Requester 2 drops req_valid after 2 accepted words.
   - Expect return to IDLE the next cycle and burst_cnt discarded.
   - Next grant goes to requester 3 if it is valid, even if requester 2 reasserts.
5. Assert write_rst_n=0 asynchronously mid-burst, between clock edges.
   - Expect grant_valid, fifo_write_enable and req_ready to drop immediately and word_count=0.
   - After release, requester 0 is granted first.
6. Preload word_count=65534 by streaming 65534 words, then write 3 more.
   - Expect word_count sequence 65535, 0, 1.
